// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the RV64IM iterative multiply/divide unit.
// Opcodes match the ALU encoding so one decoder field drives both blocks.
package muldiv_unit_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned CYCLES = XLEN;
    localparam int unsigned OPW    = 4;
    localparam int unsigned CNTW   = 7;

    localparam logic [OPW-1:0] OP_MUL  = 4'd8;
    localparam logic [OPW-1:0] OP_MULH = 4'd9;
    localparam logic [OPW-1:0] OP_DIV  = 4'd10;
    localparam logic [OPW-1:0] OP_REM  = 4'd11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Magnitude of a two's-complement operand (INT64_MIN maps to 2^63 unsigned).
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x);
        return x[XLEN-1] ? (~x + XLEN'(1)) : x;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 64-bit MUL/MULH/DIV/REM: one bit per cycle on a shared 128-bit
// shift register and 65-bit add/subtract path, fixed 66-cycle latency.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [OPW-1:0]    op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [XLEN-1:0]   result
);

    localparam int unsigned AW = 2 * XLEN;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]       state, state_d;
    logic [AW-1:0]    acc, acc_d;
    logic [CNTW-1:0]  cnt, cnt_d;
    logic [XLEN-1:0]  mcand, mcand_d;
    logic [XLEN-1:0]  a_q, a_q_d;
    logic [OPW-1:0]   op_q, op_q_d;
    logic             neg_res, neg_res_d;
    logic             neg_rem, neg_rem_d;
    logic             bzero, bzero_d;
    logic             ovf, ovf_d;
    logic             busy_d, done_d;
    logic [XLEN-1:0]  result_d;

    logic             is_div;
    logic [XLEN:0]    add_x, add_y, add_s;
    logic [AW-1:0]    prod_s;
    logic [XLEN-1:0]  quot_s, rem_s;

    // Shared adder: accumulate for multiply, trial-subtract for divide.
    assign is_div = op_q[1];
    assign add_x  = is_div ? {1'b0, acc[AW-2:XLEN-1]} : {1'b0, acc[AW-1:XLEN]};
    assign add_y  = is_div ? ~{1'b0, mcand} : {1'b0, mcand};
    assign add_s  = add_x + add_y + (XLEN+1)'(is_div);

    assign prod_s = neg_res ? (~acc + AW'(1)) : acc;
    assign quot_s = neg_res ? (~acc[XLEN-1:0] + XLEN'(1)) : acc[XLEN-1:0];
    assign rem_s  = neg_rem ? (~acc[AW-1:XLEN] + XLEN'(1)) : acc[AW-1:XLEN];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            acc     <= '0;
            cnt     <= '0;
            mcand   <= '0;
            a_q     <= '0;
            op_q    <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            bzero   <= 1'b0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            state   <= state_d;
            acc     <= acc_d;
            cnt     <= cnt_d;
            mcand   <= mcand_d;
            a_q     <= a_q_d;
            op_q    <= op_q_d;
            neg_res <= neg_res_d;
            neg_rem <= neg_rem_d;
            bzero   <= bzero_d;
            ovf     <= ovf_d;
            busy    <= busy_d;
            done    <= done_d;
            result  <= result_d;
        end
    end

    always_comb begin
        state_d   = state;
        acc_d     = acc;
        cnt_d     = cnt;
        mcand_d   = mcand;
        a_q_d     = a_q;
        op_q_d    = op_q;
        neg_res_d = neg_res;
        neg_rem_d = neg_rem;
        bzero_d   = bzero;
        ovf_d     = ovf;
        busy_d    = busy;
        done_d    = 1'b0;
        result_d  = result;

        case (state)
            S_IDLE: begin
                if (start && (op[OPW-1:2] == 2'b10)) begin
                    a_q_d     = a;
                    op_q_d    = op;
                    mcand_d   = abs_val(b);
                    acc_d     = {XLEN'(0), abs_val(a)};
                    neg_res_d = a[XLEN-1] ^ b[XLEN-1];
                    neg_rem_d = a[XLEN-1];
                    bzero_d   = (b == '0);
                    ovf_d     = (a == INT_MIN) && (b == '1);
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                if (cnt == CNTW'(CYCLES)) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt + CNTW'(1);
                    if (is_div) begin
                        // Restoring step: keep the difference only when it did not borrow.
                        if (!add_s[XLEN])
                            acc_d = {add_s[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                        else
                            acc_d = {acc[AW-2:0], 1'b0};
                    end else begin
                        if (acc[0])
                            acc_d = {add_s, acc[XLEN-1:1]};
                        else
                            acc_d = {1'b0, acc[AW-1:1]};
                    end
                end
            end
            S_FIX: begin
                case (op_q)
                    OP_MUL:  result_d = prod_s[XLEN-1:0];
                    OP_MULH: result_d = prod_s[AW-1:XLEN];
                    OP_DIV:  result_d = bzero ? '1 : (ovf ? INT_MIN : quot_s);
                    default: result_d = bzero ? a_q : (ovf ? '0 : rem_s);
                endcase
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
